toggle_evt_rx: RTL

//  Receiving end of a two-phase toggle link: the sender flips a level on `data` once per

---
 rtl/toggle_evt_rx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/toggle_evt_rx.sv
// toggle_evt_rx
// Receiving end of a two-phase toggle link. The sender flips `data` once per
// event; this block synchronises that level, turns each transition into a
// single event, and queues events in a saturating pending counter. Queued
// events are handed to a local consumer through evt_valid/ready, and each
// consumed event is returned to the sender as a flip of `ack`.
//
// Timing, counting the first edge that samples a new `data` level as edge 1:
//   edge SYNC_STAGES     : the new level reaches data_s
//   edge SYNC_STAGES + 1 : evt_pulse rises, and pending/total_count update
//
// After reset is released, transitions are ignored for SYNC_STAGES+1 cycles.
// This lets the synchroniser and the edge register fill with the real line
// level, so a line that is already high at release is not seen as an event.

module toggle_evt_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data,
  input  logic              ready,
  input  logic              clr_ovf,
  output logic              evt_pulse,
  output logic              evt_valid,
  output logic              ack,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic [CNT_W-1:0]  total_count
);

  localparam int WARM_CYC = SYNC_STAGES + 1;
  localparam int WARM_W   = $clog2(WARM_CYC + 1);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_CYC[WARM_W-1:0];
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   data_s;
  logic                   data_d;
  logic [WARM_W-1:0]      warm_cnt;
  logic                   warm_done;
  logic                   det;
  logic                   accept;
  logic                   pend_full;
  logic [PEND_W-1:0]      pend_next;
  logic                   ovf_next;

  assign data_s = sync_q[SYNC_STAGES-1];

  // Shift the raw line level through the synchroniser chain.
  // Also keep a one-cycle-old copy of the synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      data_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data};
      data_d <= data_s;
    end
  end

  // Count the settling cycles after reset is released, then stop at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= '0;
    end else if (warm_cnt != WARM_LAST) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // Form the edge detect and the handshake qualifiers from registered state.
  always_comb begin
    warm_done = (warm_cnt == WARM_LAST);
    det       = (data_s ^ data_d) & warm_done;
    evt_valid = |pending;
    accept    = evt_valid & ready;
    pend_full = (pending == PEND_MAX);
  end

  // Work out the next pending count and the next overflow state.
  // A new event at full occupancy is dropped only when nothing is accepted
  // on the same edge. A new overflow takes priority over a clear request.
  always_comb begin
    pend_next = pending;
    ovf_next  = overflow;
    if (det && !accept) begin
      if (pend_full) begin
        ovf_next = 1'b1;
      end else begin
        pend_next = pending + 1'b1;
      end
    end else if (!det && accept) begin
      pend_next = pending - 1'b1;
    end
    if (clr_ovf && !(det && !accept && pend_full)) begin
      ovf_next = 1'b0;
    end
  end

  // Register the event strobe, the queue state, and the running event total.
  // The total counts every detected event, including events that were dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_pulse   <= 1'b0;
      pending     <= '0;
      overflow    <= 1'b0;
      total_count <= '0;
    end else begin
      evt_pulse <= det;
      pending   <= pend_next;
      overflow  <= ovf_next;
      if (det) begin
        total_count <= total_count + 1'b1;
      end
    end
  end

  // Flip the acknowledge level once for each event the consumer accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0;
    end else if (accept) begin
      ack <= ~ack;
    end
  end

endmodule
